// File: rtl/traffic_light_ctrl_param.sv
// Two-road traffic light controller: latched local request, local-road gap-out, optional
// night flash mode (compiled in when TLC_FLASH_MODE_EN is defined).
module traffic_light_ctrl_param #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned HW_GREEN_MIN = 80,
    parameter int unsigned YELLOW       = 20,
    parameter int unsigned ALL_RED      = 1,
    parameter int unsigned LR_GREEN_MIN = 20,
    parameter int unsigned LR_GREEN_MAX = 80,
    parameter int unsigned FLASH_HALF   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lr_has_car,
    input  logic       flash_mode,
    output logic [2:0] hw_light,
    output logic [2:0] lr_light,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        HW_G  = 3'd0,
        HW_Y  = 3'd1,
        HW_AR = 3'd2,
        LR_G  = 3'd3,
        LR_Y  = 3'd4,
        LR_AR = 3'd5,
        FLASH = 3'd6
    } state_e;

    localparam logic [2:0] LAMP_G   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HW_MIN_C = CNT_W'(HW_GREEN_MIN);
    localparam logic [CNT_W-1:0] YEL_C    = CNT_W'(YELLOW);
    localparam logic [CNT_W-1:0] AR_C     = CNT_W'(ALL_RED);
    localparam logic [CNT_W-1:0] LR_MIN_C = CNT_W'(LR_GREEN_MIN);
    localparam logic [CNT_W-1:0] LR_MAX_C = CNT_W'(LR_GREEN_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_lat_q, req_lat_d;
    logic [2:0]       hw_d, lr_d;
    logic             flash_req;

`ifdef TLC_FLASH_MODE_EN
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(FLASH_HALF);
    logic             blink_q, blink_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    assign flash_req = flash_mode;
`else
    logic unused_flash_mode;
    assign unused_flash_mode = flash_mode;
    assign flash_req         = 1'b0;
`endif

    assign state_o = state_q;

    // State, counters and registered lamps; lamps are loaded from the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HW_G;
            cnt_q     <= CNT_ONE;
            req_lat_q <= 1'b0;
            hw_light  <= LAMP_G;
            lr_light  <= LAMP_R;
`ifdef TLC_FLASH_MODE_EN
            blink_q   <= 1'b0;
            bcnt_q    <= CNT_ONE;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_lat_q <= req_lat_d;
            hw_light  <= hw_d;
            lr_light  <= lr_d;
`ifdef TLC_FLASH_MODE_EN
            blink_q   <= blink_d;
            bcnt_q    <= bcnt_d;
`endif
        end
    end

    // Next state, phase counter, request latch and blink
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef TLC_FLASH_MODE_EN
        blink_d = 1'b0;
        bcnt_d  = CNT_ONE;
`endif
        case (state_q)
            HW_G:  if (cnt_q >= HW_MIN_C && (req_lat_q || lr_has_car || flash_req)) state_d = HW_Y;
            HW_Y:  if (cnt_q >= YEL_C) state_d = HW_AR;
            HW_AR: if (cnt_q >= AR_C) begin
                       if (flash_req)      state_d = FLASH;
                       else if (req_lat_q) state_d = LR_G;
                       else                state_d = HW_G;
                   end
            LR_G:  if (cnt_q >= LR_MAX_C || (cnt_q >= LR_MIN_C && !lr_has_car)) state_d = LR_Y;
            LR_Y:  if (cnt_q >= YEL_C) state_d = LR_AR;
            LR_AR: if (cnt_q >= AR_C) state_d = HW_G;
`ifdef TLC_FLASH_MODE_EN
            FLASH: if (!flash_mode) state_d = LR_AR;
`endif
            default: state_d = HW_G;
        endcase

        // Saturate in the open-ended states so a long dwell never wraps
        if (state_d != state_q)                      cnt_d = CNT_ONE;
        else if (state_q == HW_G && cnt_q >= HW_MIN_C) cnt_d = cnt_q;
        else if (state_q == FLASH && cnt_q == '1)    cnt_d = cnt_q;
        else                                         cnt_d = cnt_q + CNT_ONE;

        if (state_d == LR_G && state_q != LR_G)      req_lat_d = 1'b0;
        else if (lr_has_car && state_d != LR_G)      req_lat_d = 1'b1;
        else                                         req_lat_d = req_lat_q;

`ifdef TLC_FLASH_MODE_EN
        if (state_q == FLASH && state_d == FLASH) begin
            if (bcnt_q >= HALF_C) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
                bcnt_d  = bcnt_q + CNT_ONE;
            end
        end
`endif
    end

    // Moore lamp decode of the upcoming state
    always_comb begin
        hw_d = LAMP_R;
        lr_d = LAMP_R;
        case (state_d)
            HW_G: hw_d = LAMP_G;
            HW_Y: hw_d = LAMP_Y;
            LR_G: lr_d = LAMP_G;
            LR_Y: lr_d = LAMP_Y;
`ifdef TLC_FLASH_MODE_EN
            FLASH: begin
                hw_d = blink_d ? LAMP_OFF : LAMP_Y;
                lr_d = blink_d ? LAMP_OFF : LAMP_R;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Scoreboard bench for traffic_light_ctrl_param: a phase/elapsed-time reference model
// queues expected outputs per cycle; a monitor compares them after each rising edge.
module tb_traffic_light_ctrl_param;

    localparam int HGMIN = 8;
    localparam int YEL   = 3;
    localparam int AR    = 1;
    localparam int LMIN  = 4;
    localparam int LMAX  = 10;
    localparam int FH    = 2;
`ifdef TLC_FLASH_MODE_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    typedef struct {
        logic [2:0] st;
        logic [2:0] hw;
        logic [2:0] lr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lr_has_car = 1'b0;
    logic       flash_mode = 1'b0;
    logic [2:0] hw_light, lr_light, state_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Reference model: phase number, cycles spent in phase (1 on entry), pending request
    int m_ph  = 0;
    int m_el  = 1;
    bit m_req = 1'b0;

    traffic_light_ctrl_param #(
        .CNT_W(8), .HW_GREEN_MIN(HGMIN), .YELLOW(YEL), .ALL_RED(AR),
        .LR_GREEN_MIN(LMIN), .LR_GREEN_MAX(LMAX), .FLASH_HALF(FH)
    ) dut (
        .clk(clk), .rst(rst), .lr_has_car(lr_has_car), .flash_mode(flash_mode),
        .hw_light(hw_light), .lr_light(lr_light), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lamps(input int ph, input bit bl);
        case (ph)
            0:       return {3'b100, 3'b001};
            1:       return {3'b010, 3'b001};
            3:       return {3'b001, 3'b100};
            4:       return {3'b001, 3'b010};
            6:       return bl ? 6'b000_000 : {3'b010, 3'b001};
            default: return {3'b001, 3'b001};
        endcase
    endfunction

    task automatic model_step(input bit car, input bit fl, input bit r, output exp_t e);
        int nph;
        logic [5:0] lmp;
        if (r) begin
            m_ph = 0; m_el = 1; m_req = 1'b0;
        end else begin
            nph = m_ph;
            case (m_ph)
                0: if (m_el >= HGMIN && (m_req || car || (FEN && fl))) nph = 1;
                1: if (m_el >= YEL) nph = 2;
                2: if (m_el >= AR) nph = (FEN && fl) ? 6 : (m_req ? 3 : 0);
                3: if (m_el >= LMAX || (m_el >= LMIN && !car)) nph = 4;
                4: if (m_el >= YEL) nph = 5;
                5: if (m_el >= AR) nph = 0;
                6: if (!fl) nph = 5;
                default: nph = 0;
            endcase
            if (nph == 3 && m_ph != 3) m_req = 1'b0;
            else if (car && nph != 3)  m_req = 1'b1;
            m_el = (nph != m_ph) ? 1 : m_el + 1;
            m_ph = nph;
        end
        lmp  = lamps(m_ph, (m_ph == 6) && (((m_el - 1) / FH) % 2 == 1));
        e.st = 3'(m_ph);
        e.hw = lmp[5:3];
        e.lr = lmp[2:0];
    endtask

    task automatic drive(input bit car, input bit fl, input bit r);
        exp_t e;
        @(negedge clk);
        lr_has_car = car;
        flash_mode = fl;
        rst        = r;
        model_step(car, fl, r, e);
        exp_q.push_back(e);
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, want);
        end
    endtask

    // Monitor: one expected entry per clock edge after stimulus starts
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check3("state_o", state_o, e.st);
                check3("hw_light", hw_light, e.hw);
                check3("lr_light", lr_light, e.lr);
                checks++;
                if (hw_light == 3'b100 && lr_light == 3'b100) begin
                    failures++;
                    $display("FAIL green_conflict at %0t: hw %b lr %b", $time, hw_light, lr_light);
                end
            end
        end
    end

    initial begin
        bit fl;
        // Reset, then full cycle with the car held
        repeat (2) drive(0, 0, 1);
        repeat (32) drive(1, 0, 0);
        // Single-cycle pulse at cycle 3
        drive(0, 0, 1);
        drive(0, 0, 0); drive(0, 0, 0); drive(1, 0, 0);
        repeat (25) drive(0, 0, 0);
        // No request for a long time, then a late car
        drive(0, 0, 1);
        repeat (200) drive(0, 0, 0);
        drive(1, 0, 0);
        repeat (20) drive(0, 0, 0);
        // Reset in the middle of local-road yellow
        drive(0, 0, 1);
        for (int i = 0; i < 100 && m_ph != 4; i++) drive(1, 0, 0);
        drive(0, 0, 1);
        repeat (20) drive(0, 0, 0);
        // Flash request from cycle 2, then release
        drive(0, 0, 1);
        drive(0, 0, 0);
        repeat (30) drive(0, 1, 0);
        repeat (15) drive(0, 0, 0);
        // Car pulse during local yellow must be remembered
        drive(0, 0, 1);
        for (int i = 0; i < 100 && m_ph != 4; i++) drive(1, 0, 0);
        drive(1, 0, 0);
        repeat (30) drive(0, 0, 0);
        // Randomised traffic, flash toggling and occasional reset
        fl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) fl = ~fl;
            drive($urandom_range(0, 4) == 0, fl, $urandom_range(0, 249) == 0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl_param.md
Name: traffic_light_ctrl_param

Overview:
- Parametrised successor to the two-road (highway / local road) traffic light controller.
- Moore FSM with a single shared phase counter. All phase durations are parameters.
- Adds three behaviours:
  - a latched local-road request, so a single-cycle car pulse is never lost;
  - local-road green gap-out between a minimum and a maximum green time;
  - night flash mode.
- Sits at the top of the intersection lab design and drives the two 3-bit lamp groups directly.

Parameters:
- CNT_W, 8: phase counter width. Every duration parameter must be ≤ 2^CNT_W−1 and ≥ 1.
- HW_GREEN_MIN, 80: minimum highway green, in cycles.
- YELLOW, 20: yellow duration for either road, in cycles.
- ALL_RED, 1: all-red clearance after either yellow, in cycles.
- LR_GREEN_MIN, 20: local-road green before gap-out is allowed, in cycles.
- LR_GREEN_MAX, 80: maximum local-road green, in cycles.
- FLASH_HALF, 10: half-period of the flash blink, in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- lr_has_car  in  1  local-road car sensor, level or pulse.
- flash_mode  in  1  request for night flash operation.
- hw_light  out  3  highway lamps {G,Y,R}: 100 green, 010 yellow, 001 red, 000 dark.
- lr_light  out  3  local-road lamps, same encoding.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst high at a clk edge):
  - state = HW_G (encoding 0), counter = 1, req_lat = 0, blink = 0.
  - hw_light = 100, lr_light = 001.
  - Reset asserted mid-phase aborts the phase; HW_G is entered on the next edge.
- State encoding: HW_G=0, HW_Y=1, HW_AR=2, LR_G=3, LR_Y=4, LR_AR=5, FLASH=6. The value 7 recovers to HW_G with counter = 1.
- Counter:
  - Loaded with 1 on every state entry and incremented each cycle while in the state.
  - A phase of N cycles exits on the edge where counter ≥ N.
  - In HW_G and FLASH the counter saturates; it never wraps.
- req_lat:
  - Set on any edge where lr_has_car = 1 and the next state is not LR_G.
  - Cleared on the edge entering LR_G.
  - Set takes priority except on that entry edge.
- Transitions:
  - HW_G → HW_Y when counter ≥ HW_GREEN_MIN and (req_lat or lr_has_car or flash_mode); otherwise stay.
  - HW_Y → HW_AR after YELLOW cycles.
  - HW_AR → FLASH if flash_mode; else → LR_G if req_lat; else → HW_G. This is evaluated after ALL_RED cycles.
  - LR_G → LR_Y when counter ≥ LR_GREEN_MAX, or when counter ≥ LR_GREEN_MIN and lr_has_car = 0 (gap-out).
  - LR_Y → LR_AR after YELLOW cycles.
  - LR_AR → HW_G after ALL_RED cycles.
  - FLASH → LR_AR when flash_mode = 0. The next edge loads counter = 1, so clearance is always all-red before the highway green.
- Lamps are a Moore decode of state:
  - HW_G: hw 100, lr 001.
  - HW_Y: hw 010, lr 001.
  - LR_G: hw 001, lr 100.
  - LR_Y: hw 001, lr 010.
  - HW_AR and LR_AR: hw 001, lr 001.
  - FLASH: hw = blink ? 000 : 010; lr = blink ? 000 : 001.
- Blink:
  - Toggles every FLASH_HALF cycles while in FLASH, using a separate blink counter.
  - Forced to 0 on FLASH entry and outside FLASH.
- Simultaneous events:
  - flash_mode has priority over req_lat at HW_AR.
  - flash_mode is not sampled in the LR states; the local road always completes its phase.
- Green conflict: both roads green at once is forbidden in every state, including during reset.
- Latency: lamps change on the same edge as the state register; there is no extra output register.

Optional Feature:
- Macro: TLC_FLASH_MODE_EN.
- Defined: FLASH state, blink logic and flash_mode sampling exist exactly as described above.
- Undefined:
  - flash_mode is ignored; the port remains for a stable interface.
  - HW_G exits only on a request.
  - HW_AR chooses only between LR_G and HW_G.
  - Encoding 6 behaves like 7 and recovers to HW_G.

Test Plan (HW_GREEN_MIN=8, YELLOW=3, ALL_RED=1, LR_GREEN_MIN=4, LR_GREEN_MAX=10, FLASH_HALF=2; cycle 1 = first edge after rst falls):
- Full cycle: lr_has_car held at 1 → HW_G cycles 1–8, HW_Y 9–11, HW_AR 12, LR_G 13–22 (max), LR_Y 23–25, LR_AR 26, HW_G from 27.
- Single-cycle pulse: lr_has_car = 1 only at cycle 3 → HW_Y at cycle 9; LR_G 13–16 (gap-out at min 4); hw_light = 001 and lr_light = 100 during LR_G.
- No request: lr_has_car = 0 for 200 cycles → hw_light stays 100; counter saturates at 8 with no wrap; state_o stays 0.
- Reset mid-phase: rst pulsed for one cycle while in LR_Y → next cycle state_o = 0, hw_light = 100, lr_light = 001, req_lat = 0.
- Flash (macro defined): flash_mode = 1 from cycle 2 →
  - HW_Y at 9, HW_AR at 12, FLASH from 13;
  - hw_light alternates 010, 010, 000, 000, …;
  - flash_mode drops → one LR_AR cycle, then HW_G.
  - Macro undefined: hw_light stays 100.
- Request during LR: lr_has_car pulse during LR_Y → req_lat = 1; after HW_G minimum of 8 cycles, enters HW_Y without a new car.
